// File: rtl/processador_pkg.sv
// rtl/processador_pkg.sv - shared constants, IR field layout and fetch states
package processador_pkg;

    localparam int PC_W_PADRAO    = 8;
    localparam int INSTR_W_PADRAO = 8;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_COPY   = 3'b001;
    localparam logic [2:0] OP_READ   = 3'b010;
    localparam logic [2:0] OP_WRITE  = 3'b011;
    localparam logic [2:0] OP_IFZERO = 3'b100;
    localparam logic [2:0] OP_JUMP   = 3'b101;
    localparam logic [2:0] OP_SET    = 3'b110;
    localparam logic [2:0] OP_STOP   = 3'b111;

    localparam int OPCODE_MSB = 7;
    localparam int OPCODE_LSB = 5;
    localparam int BITVER_MSB = 4;
    localparam int BITVER_LSB = 3;
    localparam int IMED_MSB   = 4;
    localparam int IMED_LSB   = 0;

    typedef enum logic [2:0] {
        INICIO,
        BUSCA,
        ESPERA,
        EXECUTA,
        PARADO
    } estado_busca_t;

endpackage

// File: rtl/proximo_pc.sv
// rtl/proximo_pc.sv - next-PC selection: page jump, relative branch or increment
module proximo_pc #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [4:0]      imediato,
    input  logic            Ji,
    input  logic            Beqz,
    input  logic            zero,
    output logic [PC_W-1:0] proximoPc
);

    logic [PC_W-1:0] deslocamento;

    assign deslocamento = {{(PC_W-5){imediato[4]}}, imediato};

    // Jump replaces only the low five bits, staying inside the current 32-word page
    always_comb begin
        proximoPc = pc + 1'b1;
        if (Ji) begin
            proximoPc = {pc[PC_W-1:5], imediato};
        end else if (Beqz && zero) begin
            proximoPc = pc + deslocamento;
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - instruction fetch stage: PC, memory handshake and IR
module busca_instrucao
    import processador_pkg::*;
#(
    parameter int PC_W    = PC_W_PADRAO,
    parameter int INSTR_W = INSTR_W_PADRAO
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               EscPC,
    input  logic               Ji,
    input  logic               Beqz,
    input  logic               STOP,
    input  logic               zero,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               mem_valid,
    output logic [2:0]         opcode,
    output logic [1:0]         BitVerificacao,
    output logic [4:0]         imediato,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               parado
);

    estado_busca_t      estado;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    pcProx;

    assign opcode         = ir[OPCODE_MSB:OPCODE_LSB];
    assign BitVerificacao = ir[BITVER_MSB:BITVER_LSB];
    assign imediato       = ir[IMED_MSB:IMED_LSB];
    assign mem_addr       = pc;

    proximo_pc #(.PC_W(PC_W)) u_proximo_pc (
        .pc        (pc),
        .imediato  (imediato),
        .Ji        (Ji),
        .Beqz      (Beqz),
        .zero      (zero),
        .proximoPc (pcProx)
    );

    // mem_req, instr_valid and parado are set on entry to the state they belong to
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= INICIO;
            pc          <= '0;
            ir          <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            parado      <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            case (estado)
                INICIO: begin
                    estado  <= BUSCA;
                    mem_req <= 1'b1;
                end
                BUSCA: begin
                    estado <= ESPERA;
                end
                ESPERA: begin
                    if (mem_valid) begin
                        ir          <= mem_data;
                        estado      <= EXECUTA;
                        instr_valid <= 1'b1;
                    end
                end
                EXECUTA: begin
                    if (STOP) begin
                        estado      <= PARADO;
                        instr_valid <= 1'b0;
                        parado      <= 1'b1;
                    end else if (EscPC) begin
                        pc          <= pcProx;
                        estado      <= BUSCA;
                        mem_req     <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                PARADO: begin
                    parado <= 1'b1;
                end
                default: begin
                    estado <= INICIO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// tb/tb_busca_instrucao.sv - directed self-checking bench for busca_instrucao
module tb_busca_instrucao;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       EscPC, Ji, Beqz, STOP, zero;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_valid;
    logic [2:0] opcode;
    logic [1:0] BitVerificacao;
    logic [4:0] imediato;
    logic       instr_valid;
    logic [7:0] pc;
    logic       parado;

    logic [7:0] mem [256];
    int total  = 0;
    int passou = 0;

    always #5 clock = ~clock;

    busca_instrucao #(.PC_W(8), .INSTR_W(8)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .EscPC          (EscPC),
        .Ji             (Ji),
        .Beqz           (Beqz),
        .STOP           (STOP),
        .zero           (zero),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_valid      (mem_valid),
        .opcode         (opcode),
        .BitVerificacao (BitVerificacao),
        .imediato       (imediato),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .parado         (parado)
    );

    task automatic confere(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        total++;
        if (obtido === esperado) passou++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obtido, esperado);
    endtask

    task automatic ciclo();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic busca(input logic [7:0] endEsp, input int lat, input string tag);
        int n = 0;
        logic [7:0] palavra;
        palavra = mem[endEsp];
        while (mem_req !== 1'b1 && n < 8) begin
            ciclo();
            n++;
        end
        confere({tag, "_req"}, mem_req, 1);
        confere({tag, "_addr"}, mem_addr, endEsp);
        for (int i = 1; i < lat; i++) begin
            ciclo();
            confere({tag, "_espera_req"}, mem_req, 0);
            confere({tag, "_espera_addr"}, mem_addr, endEsp);
        end
        ciclo();
        mem_valid = 1'b1;
        mem_data  = palavra;
        ciclo();
        mem_valid = 1'b0;
        mem_data  = 8'h00;
        confere({tag, "_valid"}, instr_valid, 1);
        confere({tag, "_ir"}, {opcode, imediato}, {palavra[7:5], palavra[4:0]});
    endtask

    task automatic passo(input logic j, input logic b, input logic z, input logic [7:0] pcEsp, input string tag);
        EscPC = 1'b1;
        Ji    = j;
        Beqz  = b;
        zero  = z;
        ciclo();
        EscPC = 1'b0;
        Ji    = 1'b0;
        Beqz  = 1'b0;
        zero  = 1'b0;
        confere({tag, "_pc"}, pc, pcEsp);
        confere({tag, "_req"}, mem_req, 1);
    endtask

    initial begin
        int reqs;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h05;
        mem[8'h01] = 8'hB0;
        mem[8'h11] = 8'h8F;
        mem[8'h20] = 8'h9C;
        mem[8'h21] = 8'h9F;
        mem[8'h1C] = 8'h8F;
        mem[8'h2B] = 8'h8F;
        mem[8'h3A] = 8'h8F;
        mem[8'h49] = 8'hA5;
        mem[8'h45] = 8'hA3;
        mem[8'h07] = 8'hE0;

        reset_n = 1'b0;
        {EscPC, Ji, Beqz, STOP, zero, mem_valid} = '0;
        mem_data = 8'h00;
        ciclo();
        ciclo();
        confere("rst_pc", pc, 0);
        confere("rst_outs", {mem_req, instr_valid, parado, opcode}, 0);

        reset_n = 1'b1;
        confere("inicio_req", mem_req, 0);
        ciclo();
        confere("e1_req", mem_req, 1);
        confere("e1_addr", mem_addr, 8'h00);
        ciclo();
        confere("e2_req", mem_req, 0);
        mem_valid = 1'b1;
        mem_data  = 8'h05;
        ciclo();
        mem_valid = 1'b0;
        confere("e3_valid", instr_valid, 1);
        confere("e3_opcode", opcode, 3'b000);
        confere("e3_imed", imediato, 5'b00101);

        ciclo();
        confere("multiciclo_valid", instr_valid, 1);
        passo(0, 0, 0, 8'h01, "inc0");
        busca(8'h01, 1, "f01");
        passo(1, 0, 0, 8'h10, "jmp10");
        busca(8'h10, 1, "f10");
        passo(0, 0, 0, 8'h11, "inc10");
        busca(8'h11, 4, "lat4");

        mem_valid = 1'b1;
        mem_data  = 8'hFF;
        ciclo();
        mem_valid = 1'b0;
        confere("espurio_ir", {opcode, imediato}, {3'b100, 5'b01111});
        confere("espurio_valid", instr_valid, 1);

        passo(0, 1, 1, 8'h20, "br11");
        busca(8'h20, 1, "f20");
        passo(0, 1, 0, 8'h21, "br_z0");
        busca(8'h21, 1, "f21");
        passo(0, 1, 1, 8'h20, "br_m1");
        busca(8'h20, 1, "f20b");
        passo(0, 1, 1, 8'h1C, "br_m4");
        busca(8'h1C, 1, "f1c");
        passo(0, 1, 1, 8'h2B, "hop1");
        busca(8'h2B, 1, "f2b");
        passo(0, 1, 1, 8'h3A, "hop2");
        busca(8'h3A, 1, "f3a");
        passo(0, 1, 1, 8'h49, "hop3");
        busca(8'h49, 1, "f49");
        passo(1, 0, 0, 8'h45, "jmp45");
        busca(8'h45, 1, "f45");
        passo(1, 1, 1, 8'h43, "ji_prio");
        busca(8'h43, 1, "f43");
        passo(0, 0, 0, 8'h44, "inc43");

        mem[8'h00] = 8'h9F;
        ciclo();
        reset_n = 1'b0;
        #1;
        confere("rst_mid_pc", pc, 0);
        confere("rst_mid_outs", {parado, opcode, instr_valid, mem_req}, 0);
        ciclo();
        reset_n = 1'b1;
        busca(8'h00, 1, "refetch0");
        passo(0, 1, 1, 8'hFF, "wrap_sub");
        busca(8'hFF, 1, "fff");
        mem[8'h00] = 8'hA7;
        passo(0, 0, 0, 8'h00, "wrap_inc");
        busca(8'h00, 1, "f00c");
        passo(1, 0, 0, 8'h07, "jmp07");
        busca(8'h07, 1, "f07");

        STOP  = 1'b1;
        EscPC = 1'b1;
        ciclo();
        STOP = 1'b0;
        confere("halt_parado", parado, 1);
        confere("halt_pc", pc, 8'h07);
        confere("halt_valid", instr_valid, 0);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            EscPC     = 1'b1;
            STOP      = i[0];
            mem_valid = 1'b1;
            mem_data  = 8'h00;
            ciclo();
            if (mem_req) reqs++;
        end
        {EscPC, STOP, mem_valid} = '0;
        confere("halt_reqs", reqs, 0);
        confere("halt_pc_hold", pc, 8'h07);
        confere("halt_ir_hold", opcode, 3'b111);
        confere("halt_parado_hold", parado, 1);

        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction-fetch stage that sits directly upstream of the Controle block in the multicycle processor. It holds the PC, fetches one instruction word per instruction through a request/valid handshake with instruction memory, and latches it in the instruction register (IR). It presents opcode and BitVerificacao to Controle. It consumes Controle's EscPC/Ji/Beqz/STOP outputs to compute the next PC, or to halt.

Parameters:
PC_W, 8, PC and instruction-memory address width
INSTR_W, 8, instruction word width; fixed field layout below requires INSTR_W = 8

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
EscPC  in  1  from Controle: current instruction done, advance PC
Ji  in  1  from Controle: unconditional jump
Beqz  in  1  from Controle: branch-if-zero instruction
STOP  in  1  from Controle: halt processor
zero  in  1  from ULA/register file: tested register equals 0
mem_req  out  1  one-cycle fetch request to instruction memory
mem_addr  out  PC_W  fetch address, equals pc
mem_data  in  INSTR_W  instruction word returned
mem_valid  in  1  mem_data valid this cycle
opcode  out  3  IR[7:5], to Controle
BitVerificacao  out  2  IR[4:3], to Controle
imediato  out  5  IR[4:0], jump target / branch offset / SET operand
instr_valid  out  1  IR holds the instruction currently executing
pc  out  PC_W  current PC
parado  out  1  processor halted

Behaviour:
- Reset (reset_n = 0, asynchronous): pc = 0, IR = 0 (opcode = 000), state = INICIO. All outputs 0. Applies in any state, including mid-fetch: the outstanding request is abandoned.
- FSM states: INICIO, BUSCA, ESPERA, EXECUTA, PARADO. All outputs are Moore or registered.
- INICIO: no request. Go to BUSCA on the next edge.
- BUSCA: mem_req = 1 for exactly one cycle, mem_addr = pc. Go to ESPERA.
- ESPERA: mem_req = 0, mem_addr holds pc. When mem_valid = 1: IR <= mem_data and go to EXECUTA. Memory latency is arbitrary, with a minimum of 1 cycle after the request. Wait indefinitely otherwise.
- EXECUTA: instr_valid = 1; opcode, BitVerificacao and imediato are stable from IR. Priority per cycle:
  - STOP = 1: go to PARADO. pc is unchanged.
  - Otherwise, if EscPC = 1: pc <= next PC, go to BUSCA.
  - Otherwise, stay in EXECUTA (multicycle instruction).
- Next PC, evaluated only with EscPC = 1; Ji has priority over Beqz:
  - Ji = 1: pc <= {pc[PC_W-1:5], imediato}, a jump within the 32-word page.
  - Beqz = 1 and zero = 1: pc <= pc + sign_extend(imediato), range -16..+15.
  - All other cases, including Beqz with zero = 0: pc <= pc + 1.
  - All arithmetic is modulo 2^PC_W: 0xFF + 1 = 0x00, and 0x02 + (-4) = 0xFE.
- PARADO: parado = 1, instr_valid = 0, mem_req = 0. IR and pc hold. The only exit is reset. EscPC, STOP and mem_valid are ignored.
- mem_valid outside ESPERA is ignored; IR is not written.
- mem_valid is never sampled in the same cycle mem_req is asserted.
- Latency: with 1-cycle memory, an instruction is visible in EXECUTA 3 cycles after the preceding EscPC edge (BUSCA, ESPERA, load).

Decomposition:
- Shared package (processador_pkg):
  - opcode constants: ADD=000, COPY=001, READ=010, WRITE=011, IFZERO=100, JUMP=101, SET=110, STOP=111
  - IR field positions (opcode [7:5], BitVerificacao [4:3], imediato [4:0])
  - fetch state enum
  - PC_W default
- One combinational sub-module, proximo_pc: inputs pc, imediato, Ji, Beqz, zero; output is the next PC value. It is unit-testable on its own.

Test Plan:
- Reset, then memory returns 0x05 one cycle after the request at address 0 -> mem_req pulses once with mem_addr = 0x00; opcode = 000, imediato = 00101, instr_valid = 1 on the 3rd edge after reset release.
- EXECUTA with pc = 0x10, EscPC = 1, Ji = 0, Beqz = 0 -> pc = 0x11, next fetch at 0x11. Then pc = 0xFF with EscPC -> pc wraps to 0x00.
- Branch with pc = 0x20, imediato = 11100 (-4):
  - Beqz = 1, zero = 1, EscPC = 1 -> pc = 0x1C.
  - Same case with zero = 0 -> pc = 0x21.
- pc = 0x45, imediato = 00011, Ji = 1 and Beqz = 1 together with EscPC -> Ji wins, pc = 0x43.
- Memory latency of 4 cycles -> state stays ESPERA with mem_addr stable and mem_req low. A spurious mem_valid during EXECUTA leaves IR unchanged.
- Halt and reset:
  - STOP = 1 and EscPC = 1 in the same EXECUTA cycle at pc = 0x07 -> parado = 1, pc stays 0x07, no further mem_req for 20 cycles.
  - reset_n pulsed low mid-ESPERA -> pc = 0, parado = 0, opcode = 000, and the fetch restarts from address 0.
